// File: rtl/rx_burst_dma.sv
// RX frame reassembly into 128-byte write bursts for the bus-master command FIFO.
// Each burst is a 3-word header (DW length, host address) followed by its halfwords.
module rx_burst_dma #(
  parameter int unsigned MAX_BURST_HW = 64,
  parameter int unsigned BUF_AW       = 6
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [17:0] phy_dout,
  input  logic        phy_empty,
  output logic        phy_rd_en,
  output logic [17:0] mst_din,
  input  logic        mst_full,
  output logic        mst_wr_en,
  input  logic        dma_enable,
  input  logic [19:0] dma_length,
  input  logic [29:0] dma_addr_start,
  output logic [29:0] dma_addr_cur,
  output logic        frame_intr,
  output logic [15:0] drop_count
);

  localparam int unsigned CW = BUF_AW + 1;
  localparam logic [CW-1:0] MaxCnt = CW'(MAX_BURST_HW);

  typedef enum logic [2:0] {
    StIdle, StFill, StPad, StHdr0, StHdr1, StHdr2, StData, StDrop
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       buf_q [2**BUF_AW];
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BUF_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic              rd_vld_q;
  logic              eof_q, eof_d;
  logic              pend_q, pend_d, pend_set;
  logic [17:0]       pend_word_q;
  logic [29:0]       cur_q, cur_d, baddr_q, baddr_d;
  logic              intr_q, intr_d;
  logic [15:0]       drop_q, drop_d;
  logic              wr_buf;
  logic [15:0]       wr_data;

  logic [29:0] ring_end, len30, last_end;
  logic [9:0]  len_dw;
  logic [17:0] word;
  logic        word_vld, last;

  assign ring_end = dma_addr_start + {10'b0, dma_length};
  assign len_dw   = 10'(cnt_q >> 1);
  assign len30    = {20'b0, len_dw};
  assign last_end = baddr_q + len30;
  // A SOF held over from a truncated frame takes priority over a new FIFO read.
  assign word     = pend_q ? pend_word_q : phy_dout;
  assign word_vld = pend_q | rd_vld_q;
  assign last     = ({1'b0, rd_ptr_q} == cnt_q - CW'(1));

  // Next frame starts on a 32-DW boundary, back at the ring base once past the top.
  function automatic logic [29:0] round_wrap(input logic [29:0] a);
    logic [29:0] r;
    r = (a + 30'd31) & ~30'd31;
    return (r >= ring_end) ? dma_addr_start : r;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_ptr_d  = rd_ptr_q;
    eof_d     = eof_q;
    pend_d    = pend_q;
    pend_set  = 1'b0;
    cur_d     = cur_q;
    baddr_d   = baddr_q;
    intr_d    = 1'b0;
    drop_d    = drop_q;
    wr_buf    = 1'b0;
    wr_data   = word[15:0];
    phy_rd_en = 1'b0;
    mst_wr_en = 1'b0;
    mst_din   = '0;
    unique case (state_q)
      StIdle: begin
        phy_rd_en = ~phy_empty & ~rd_vld_q & ~pend_q;
        if (!dma_enable) cur_d = dma_addr_start;
        if (word_vld) begin
          pend_d = 1'b0;
          if (word[17]) begin
            if (dma_enable) begin
              wr_buf  = 1'b1;
              cnt_d   = CW'(1);
              eof_d   = word[16];
              state_d = StFill;
            end else if (word[16]) begin
              drop_d = sat_inc(drop_q);
            end else begin
              state_d = StDrop;
            end
          end
        end
      end
      StFill: begin
        phy_rd_en = ~phy_empty & ~rd_vld_q & (cnt_q < MaxCnt) & ~eof_q;
        if (rd_vld_q) begin
          if (phy_dout[17]) begin
            // Truncated frame: close it out and keep the SOF for the next one.
            pend_set = 1'b1;
            pend_d   = 1'b1;
            eof_d    = 1'b1;
            if (cnt_q == '0) begin
              cur_d   = round_wrap(cur_q);
              intr_d  = 1'b1;
              state_d = StIdle;
            end
          end else begin
            wr_buf  = 1'b1;
            cnt_d   = cnt_q + CW'(1);
            eof_d   = phy_dout[16];
          end
        end else if (eof_q || cnt_q == MaxCnt) begin
          state_d = cnt_q[0] ? StPad : StHdr0;
        end
      end
      StPad: begin
        wr_buf  = 1'b1;
        wr_data = 16'h0000;
        cnt_d   = cnt_q + CW'(1);
        state_d = StHdr0;
      end
      StHdr0: begin
        mst_din   = {2'b01, 6'b0, len_dw};
        mst_wr_en = ~mst_full;
        if (!mst_full) begin
          baddr_d = (cur_q + len30 > ring_end) ? dma_addr_start : cur_q;
          state_d = StHdr1;
        end
      end
      StHdr1: begin
        mst_din   = {2'b01, baddr_q[29:14]};
        mst_wr_en = ~mst_full;
        if (!mst_full) state_d = StHdr2;
      end
      StHdr2: begin
        mst_din   = {2'b01, baddr_q[13:0], 2'b00};
        mst_wr_en = ~mst_full;
        if (!mst_full) begin
          rd_ptr_d = '0;
          state_d  = StData;
        end
      end
      StData: begin
        mst_din   = {last ? 2'b10 : 2'b00, buf_q[rd_ptr_q]};
        mst_wr_en = ~mst_full;
        if (!mst_full) begin
          rd_ptr_d = rd_ptr_q + BUF_AW'(1);
          if (last) begin
            cnt_d = '0;
            if (eof_q) begin
              cur_d   = round_wrap(last_end);
              intr_d  = 1'b1;
              state_d = StIdle;
            end else begin
              cur_d   = last_end;
              state_d = StFill;
            end
          end
        end
      end
      StDrop: begin
        phy_rd_en = ~phy_empty & ~rd_vld_q;
        if (rd_vld_q && phy_dout[16]) begin
          drop_d  = sat_inc(drop_q);
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rd_ptr_q    <= '0;
      rd_vld_q    <= 1'b0;
      eof_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_word_q <= '0;
      cur_q       <= '0;
      baddr_q     <= '0;
      intr_q      <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      rd_vld_q <= phy_rd_en;
      eof_q    <= eof_d;
      pend_q   <= pend_d;
      if (pend_set) pend_word_q <= phy_dout;
      cur_q    <= cur_d;
      baddr_q  <= baddr_d;
      intr_q   <= intr_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_buf) buf_q[cnt_q[BUF_AW-1:0]] <= wr_data;
  end

  assign dma_addr_cur = cur_q;
  assign frame_intr   = intr_q;
  assign drop_count   = drop_q;

endmodule
